// File: rtl/fft_result_capture.sv
// Captures one natural-order frame from the streaming FFT and serves it through a registered read port.
// Optional peak-magnitude tracking is built when FFT_CAPTURE_PEAK_EN is defined.
module fft_result_capture #(
  parameter int unsigned N_POINTS = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     fft_out_valid,
  input  logic signed [DATA_W-1:0] fft_dout_r,
  input  logic signed [DATA_W-1:0] fft_dout_i,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          count,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_valid,
  output logic signed [DATA_W-1:0] rd_data_r,
  output logic signed [DATA_W-1:0] rd_data_i,
  output logic [ADDR_W-1:0]        peak_idx,
  output logic [2*DATA_W-1:0]      peak_mag
);

  localparam int unsigned SAMP_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_POINTS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state;
  logic [SAMP_W-1:0] mem [N_POINTS];
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_idx_c;

  // A restart pulse wins over a coincident sample, which is dropped.
  always_comb begin
    wr_en_c  = !reset && !start && fft_out_valid && (state == ARMED || state == CAPTURE);
    wr_idx_c = (state == ARMED) ? '0 : count[ADDR_W-1:0];
  end

  // Frame buffer: never reset, contents persist across reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_idx_c] <= {fft_dout_r, fft_dout_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      rd_valid  <= 1'b0;
      rd_data_r <= '0;
      rd_data_i <= '0;
    end else begin
      // Read-before-write falls out of the nonblocking update of mem.
      rd_valid <= rd_en;
      if (rd_en) {rd_data_r, rd_data_i} <= mem[rd_addr];

      case (state)
        IDLE: begin
          if (start) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (start) begin
            count <= '0;
          end else if (fft_out_valid) begin
            count <= CNT_W'(1);
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (start) begin
            state <= ARMED;
            count <= '0;
          end else if (fft_out_valid) begin
            count <= count + CNT_W'(1);
            if (count == LAST_CNT) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state <= ARMED;
            busy  <= 1'b1;
            done  <= 1'b0;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

`ifdef FFT_CAPTURE_PEAK_EN
  logic signed [SAMP_W-1:0] sq_r_c;
  logic signed [SAMP_W-1:0] sq_i_c;
  logic [SAMP_W-1:0]        mag_c;

  // r^2 + i^2 peaks at 2^31, which fits the unsigned SAMP_W result.
  always_comb begin
    sq_r_c = fft_dout_r * fft_dout_r;
    sq_i_c = fft_dout_i * fft_dout_i;
    mag_c  = $unsigned(sq_r_c) + $unsigned(sq_i_c);
  end

  // Strictly-greater compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      peak_idx <= '0;
      peak_mag <= '0;
    end else if (wr_en_c && (mag_c > peak_mag)) begin
      peak_idx <= wr_idx_c;
      peak_mag <= mag_c;
    end
  end
`else
  assign peak_idx = '0;
  assign peak_mag = '0;
`endif

endmodule

// File: doc/fft_result_capture.md
# fft_result_capture

Downstream stage of the 32-point streaming FFT core. It consumes the core's output stream (`out_valid`, 16-bit signed `dout_r`/`dout_i`) and stores exactly one frame of N complex results in natural order. It exposes that frame through a registered random-access read port for the RS5 accelerator bus interface, along with busy/done status.

## Interface
Parameters:
- `N_POINTS`, default 32: samples captured per frame; must be a power of two.
- `DATA_W`, default 16: width of each real and imaginary component.
- `ADDR_W`, default 5: read address width; equals log2(`N_POINTS`).

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that arms a new capture.
- `fft_out_valid`, in, 1: FFT output valid; may stay high indefinitely.
- `fft_dout_r`, `fft_dout_i`, in, `DATA_W`: FFT output sample, signed.
- `busy`, out, 1: high in ARMED or CAPTURE.
- `done`, out, 1: level; high while a complete frame is held.
- `count`, out, `ADDR_W`+1: number of samples written in the current frame.
- `rd_en`, in, 1: read request.
- `rd_addr`, in, `ADDR_W`: read index.
- `rd_valid`, out, 1: read data valid.
- `rd_data_r`, `rd_data_i`, out, `DATA_W`: read data, signed.
- `peak_idx`, out, `ADDR_W`: index of the largest magnitude in the frame (see Configuration).
- `peak_mag`, out, 2*`DATA_W`: largest r²+i² in the frame (see Configuration).

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE to ARMED on `start`. DONE to ARMED on `start`; `done` clears.
- ARMED: on a cycle with `fft_out_valid`=1, write the sample to index 0, set `count`=1, go to CAPTURE.
- CAPTURE: each cycle with `fft_out_valid`=1, write the sample to index `count` and increment `count`.
  - If `fft_out_valid`=0, stall: no write, no increment.
  - The write to index N-1 moves the block to DONE (`count`=N).
- DONE: ignore `fft_out_valid`; hold the buffer contents.
- `start` in ARMED or CAPTURE restarts the capture: go to ARMED, set `count`=0, leave the buffer untouched. `start` has priority over a same-cycle write; that sample is dropped.
- Buffer is N×(2·`DATA_W`) storage and is not reset. Contents are undefined until first written.
- Reads are accepted in every state.
  - If a read and a write hit the same index in the same cycle, the read returns the old data (read-before-write).
  - `rd_addr` ≥ N is impossible by width; no check is required.
- Magnitude arithmetic: r²+i² computed from the signed products, result unsigned, 2·`DATA_W` bits.
  - Maximum value is 2·2³⁰ = 2³¹; it fits without overflow.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rd_valid` = 0; `count` = 0; `rd_data_r`, `rd_data_i`, `peak_idx`, `peak_mag` = 0.
- Reset mid-capture aborts immediately. No state survives reset except the buffer contents.
- Write latency: sample presented on cycle t is stored at edge t.
  - `count` reflects the write at t+1.
  - `done` rises at t+1 after the write to index N-1; `busy` falls in the same cycle.
- `busy` rises the cycle after `start`.
- Read latency is 1: `rd_en` at edge t gives `rd_data_*` and `rd_valid`=1 during cycle t+1.
  - `rd_valid` is a single-cycle pulse per request.
  - Back-to-back reads run at full rate.
  - `rd_data_*` holds its last value when `rd_valid`=0.
- A minimum frame with `fft_out_valid` continuously high takes N cycles from the first accepted sample to `done`.

## Configuration
- Macro: `FFT_CAPTURE_PEAK_EN`.
- Defined:
  - `peak_mag` and `peak_idx` are cleared on `start`.
  - They are updated registered on each accepted write when the sample's magnitude is strictly greater than `peak_mag`. Ties keep the lower index.
  - Values are final when `done` rises, in the same cycle.
- Undefined: no multipliers are instantiated, and `peak_idx`/`peak_mag` are tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- `start`, then 32 consecutive valid samples with r=k, i=-k for k=0..31 -> `done` rises 32 cycles after the first sample; reading addr 7 gives r=7, i=-7 with `rd_valid` one cycle after `rd_en`.
- Capture with `fft_out_valid` low for 3 cycles after sample 10 -> `count` holds at 11 during the gap; all 32 samples land at correct indices; `done` is delayed by 3 cycles.
- `start` pulsed at `count`=20 while valid stays high -> the sample in the `start` cycle is dropped; the next sample goes to index 0; `done` follows after a further 32 samples.
- `reset` asserted at `count`=15 -> next cycle shows `busy`=0, `done`=0, `count`=0; the block stays IDLE with valid high until `start`.
- With `FFT_CAPTURE_PEAK_EN`, samples all (1,1) except index 9 = (300,-400) and index 20 = (-400,300) -> `peak_mag`=250000, `peak_idx`=9. Without the macro, both outputs read 0.
- Read addr 4 in the same cycle index 4 is written with (55,66) over old (1,2) -> returns (1,2); a repeat read returns (55,66).
